// File: rtl/line_buffer_writer_pkg.sv
// ---------------------------------------------------------------------------
// line_buffer_writer_pkg
//   Shared video constants and types for the composite-video line store.
//   Holds the line geometry, the colour-number width, the BLACK code returned
//   for masked reads, the writer state enum and the bank addressing helper.
// ---------------------------------------------------------------------------
package line_buffer_writer_pkg;

    localparam int PIXELS_PER_LINE = 320;
    localparam int COLOUR_W        = 8;
    localparam int PTR_W           = 9;

    // One extra address bit selects between the two line banks.
    localparam int ADDR_W          = PTR_W + 1;
    localparam int RAM_DEPTH       = 2 * PIXELS_PER_LINE;

    localparam logic [COLOUR_W-1:0] BLACK = '0;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } writer_state_t;

    // Bank 0 occupies words 0..PIXELS-1, bank 1 the next PIXELS words, so the
    // RAM stays exactly 2*PIXELS deep instead of rounding up to a power of two.
    function automatic logic [ADDR_W-1:0] bankAddr(input logic bank,
                                                   input logic [PTR_W-1:0] ptr);
        logic [ADDR_W-1:0] base;
        base = bank ? ADDR_W'(PIXELS_PER_LINE) : '0;
        return base + {1'b0, ptr};
    endfunction

endpackage

// File: rtl/line_bank_ram.sv
// ---------------------------------------------------------------------------
// line_bank_ram
//   Simple dual-port RAM holding both line banks. One synchronous write port
//   and one registered read port, written so synthesis maps it to block RAM.
//   Ports:
//     clk    - system clock
//     we     - write enable
//     waddr  - write address
//     wdata  - write data
//     raddr  - read address
//     rdata  - read data, valid one cycle after raddr
// ---------------------------------------------------------------------------
module line_bank_ram
    import line_buffer_writer_pkg::*;
#(
    parameter int DEPTH  = RAM_DEPTH,
    parameter int AW     = ADDR_W,
    parameter int DW     = COLOUR_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port and registered read port share one clocked block with no
    // reset, which is the template block-RAM inference expects. Contents are
    // deliberately left uninitialised; the writer masks reads until a full
    // line has been swapped in.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/line_buffer_writer.sv
// ---------------------------------------------------------------------------
// line_buffer_writer
//   Write side of the ping-pong line store. Fills the write bank from the
//   pixel stream, swaps banks on lineSync once the bank is full, and serves
//   the display side from the other bank with one cycle of read latency.
//   Ports:
//     clk          - system clock, rising edge
//     reset_n      - asynchronous active-low reset
//     pixelIn      - colour number from the pixel source
//     pixelValid   - pixelIn valid this cycle
//     pixelReady   - writer accepts a pixel this cycle (high in FILL)
//     lineRestart  - discard the partial line being written
//     lineSync     - start-of-line pulse from video timing
//     pixelPtr     - display read pointer
//     colourNum    - colour number for pixelPtr, one cycle later
//     lineUnderrun - one-cycle pulse when lineSync found the bank not full
// ---------------------------------------------------------------------------
module line_buffer_writer
    import line_buffer_writer_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [COLOUR_W-1:0] pixelIn,
    input  logic                pixelValid,
    output logic                pixelReady,
    input  logic                lineRestart,
    input  logic                lineSync,
    input  logic [PTR_W-1:0]    pixelPtr,
    output logic [COLOUR_W-1:0] colourNum,
    output logic                lineUnderrun
);

    writer_state_t        state;
    logic [PTR_W-1:0]     writePtr;
    logic                 writeBank;
    logic                 readValid;
    logic                 readMask;
    logic                 accept;
    logic                 lastPixel;
    logic                 ramWe;
    logic                 readInRange;
    logic [ADDR_W-1:0]    writeAddr;
    logic [ADDR_W-1:0]    readAddr;
    logic [COLOUR_W-1:0]  ramData;

    // Ready is a pure decode of the state so the source never sees a
    // combinational path from its own valid back to ready.
    assign pixelReady = (state == FILL);
    assign accept     = pixelValid && pixelReady;
    assign lastPixel  = (writePtr == PTR_W'(PIXELS_PER_LINE - 1));

    // A restart in the same cycle as an accept drops that pixel, so the RAM
    // write is suppressed rather than landing at a pointer about to be reset.
    assign ramWe      = accept && !lineRestart;
    assign writeAddr  = bankAddr(writeBank, writePtr);

    // Out-of-range pointers are steered to address 0 so the RAM is never
    // indexed past its end; the registered mask forces those reads to BLACK.
    assign readInRange = (pixelPtr < PTR_W'(PIXELS_PER_LINE));
    assign readAddr    = readInRange ? bankAddr(~writeBank, pixelPtr) : '0;

    line_bank_ram u_ram (
        .clk   (clk),
        .we    (ramWe),
        .waddr (writeAddr),
        .wdata (pixelIn),
        .raddr (readAddr),
        .rdata (ramData)
    );

    // Writer FSM. FILL accepts pixels until the last one of the line, then
    // FULL holds off the source until lineSync hands the bank to the display.
    // A lineSync arriving with the final accept counts as a full line, so the
    // swap happens on that same edge. Restart only matters while filling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= FILL;
            writePtr     <= '0;
            writeBank    <= 1'b0;
            readValid    <= 1'b0;
            lineUnderrun <= 1'b0;
        end else begin
            lineUnderrun <= 1'b0;
            case (state)
                FILL: begin
                    if (lineRestart) begin
                        writePtr     <= '0;
                        lineUnderrun <= lineSync;
                    end else if (accept && lastPixel) begin
                        writePtr <= '0;
                        if (lineSync) begin
                            writeBank <= ~writeBank;
                            readValid <= 1'b1;
                        end else begin
                            state <= FULL;
                        end
                    end else begin
                        if (accept) begin
                            writePtr <= writePtr + 1'b1;
                        end
                        lineUnderrun <= lineSync;
                    end
                end
                FULL: begin
                    if (lineSync) begin
                        writeBank <= ~writeBank;
                        readValid <= 1'b1;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // The read mask travels alongside the RAM's registered read so the mask
    // and the data always describe the same pointer. It is sampled before
    // any swap on this edge, so a read in the swap cycle sees the old bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readMask <= 1'b0;
        end else begin
            readMask <= readValid && readInRange;
        end
    end

    assign colourNum = readMask ? ramData : BLACK;

endmodule

// File: tb/tb_line_buffer_writer.sv
// ---------------------------------------------------------------------------
// tb_line_buffer_writer
//   Self-checking bench for line_buffer_writer. A line-level reference model
//   (a queue for the line being written and an array for the line on
//   display) predicts pixelReady, colourNum and lineUnderrun each cycle.
// ---------------------------------------------------------------------------
module tb_line_buffer_writer;

    localparam int PIX = 320;

    logic       clk;
    logic       reset_n;
    logic [7:0] pixelIn;
    logic       pixelValid;
    logic       pixelReady;
    logic       lineRestart;
    logic       lineSync;
    logic [8:0] pixelPtr;
    logic [7:0] colourNum;
    logic       lineUnderrun;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state
    logic [7:0] lineQ[$];
    logic [7:0] disp [PIX];
    bit         dispValid = 0;

    line_buffer_writer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pixelIn      (pixelIn),
        .pixelValid   (pixelValid),
        .pixelReady   (pixelReady),
        .lineRestart  (lineRestart),
        .lineSync     (lineSync),
        .pixelPtr     (pixelPtr),
        .colourNum    (colourNum),
        .lineUnderrun (lineUnderrun)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle of stimulus; predicts and checks every output
    task automatic applyStimulus(input logic v, input logic [7:0] p, input logic rs,
                                 input logic sy, input logic [8:0] ptr);
        logic [7:0] expColour;
        logic       expUnder;
        bit         full;
        @(negedge clk);
        pixelValid  = v;
        pixelIn     = p;
        lineRestart = rs;
        lineSync    = sy;
        pixelPtr    = ptr;
        #1;
        full = (lineQ.size() == PIX);
        checkOutput("pixelReady", {31'd0, pixelReady}, {31'd0, !full});

        expColour = (dispValid && ptr < PIX) ? disp[ptr] : 8'h00;
        expUnder  = 1'b0;
        if (!full) begin
            if (rs) begin
                lineQ.delete();
                expUnder = sy;
            end else begin
                if (v) lineQ.push_back(p);
                if (lineQ.size() == PIX) begin
                    if (sy) begin
                        for (int i = 0; i < PIX; i++) disp[i] = lineQ[i];
                        lineQ.delete();
                        dispValid = 1;
                    end
                end else begin
                    expUnder = sy;
                end
            end
        end else if (sy) begin
            for (int i = 0; i < PIX; i++) disp[i] = lineQ[i];
            lineQ.delete();
            dispValid = 1;
        end

        @(posedge clk);
        #1;
        checkOutput("colourNum", {24'd0, colourNum}, {24'd0, expColour});
        checkOutput("lineUnderrun", {31'd0, lineUnderrun}, {31'd0, expUnder});
    endtask

    // Asynchronous reset held across a clock edge; model returns to empty
    task automatic applyReset();
        @(negedge clk);
        pixelValid  = 0;
        lineRestart = 0;
        lineSync    = 0;
        reset_n     = 0;
        #1;
        lineQ.delete();
        dispValid = 0;
        checkOutput("resetColour", {24'd0, colourNum}, 32'd0);
        checkOutput("resetUnderrun", {31'd0, lineUnderrun}, 32'd0);
        checkOutput("resetReady", {31'd0, pixelReady}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        reset_n     = 1;
        pixelIn     = 0;
        pixelValid  = 0;
        lineRestart = 0;
        lineSync    = 0;
        pixelPtr    = 0;
        applyReset();

        // Partial line then reset mid-stream; display must stay black
        for (int i = 0; i < 40; i++) applyStimulus(1, 8'(i), 0, 0, 0);
        applyReset();
        for (int i = 0; i < PIX; i++) applyStimulus(0, 0, 0, 0, 9'(i));

        // Fill with i mod 256 and swap
        for (int i = 0; i < PIX; i++) applyStimulus(1, 8'(i), 0, 0, 0);
        applyStimulus(1, 8'hEE, 0, 0, 0);
        checkOutput("fullReady", {31'd0, pixelReady}, 32'd0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 9'd5);
        checkOutput("fillRead5", {24'd0, colourNum}, 32'd5);
        applyStimulus(0, 0, 0, 0, 9'd319);
        checkOutput("fillRead319", {24'd0, colourNum}, 32'd63);

        // Underrun after 100 pixels, then complete the line
        for (int i = 0; i < 100; i++) applyStimulus(1, 8'(i + 7), 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 9'd5);
        checkOutput("underrunPulse", {31'd0, lineUnderrun}, 32'd1);
        applyStimulus(0, 0, 0, 0, 9'd5);
        checkOutput("underrunKeep", {24'd0, colourNum}, 32'd5);
        for (int i = 100; i < PIX; i++) applyStimulus(1, 8'(i + 7), 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 9'd99);
        checkOutput("underrunRead99", {24'd0, colourNum}, 32'd106);

        // Final accept coinciding with lineSync
        for (int i = 0; i < PIX - 1; i++) applyStimulus(1, 8'hC3, 0, 0, 0);
        applyStimulus(1, 8'h3C, 0, 1, 9'd319);
        checkOutput("sameCycleNoUnderrun", {31'd0, lineUnderrun}, 32'd0);
        applyStimulus(0, 0, 0, 0, 9'd319);
        checkOutput("sameCycleLast", {24'd0, colourNum}, 32'h3C);

        // Restart drops the partial line; range masking
        for (int i = 0; i < 50; i++) applyStimulus(1, 8'hAA, 0, 0, 0);
        applyStimulus(1, 8'hAA, 1, 0, 0);
        for (int i = 0; i < PIX; i++) applyStimulus(1, 8'h55, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        for (int i = 0; i < PIX; i++) applyStimulus(0, 0, 0, 0, 9'(i));
        applyStimulus(0, 0, 0, 0, 9'd320);
        checkOutput("range320", {24'd0, colourNum}, 32'd0);
        applyStimulus(0, 0, 0, 0, 9'd511);
        checkOutput("range511", {24'd0, colourNum}, 32'd0);

        // Restart together with lineSync while filling
        for (int i = 0; i < 10; i++) applyStimulus(1, 8'h77, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("restartSyncUnderrun", {31'd0, lineUnderrun}, 32'd1);

        // Ping-pong continuity over three lines
        for (int l = 1; l <= 3; l++) begin
            for (int i = 0; i < PIX; i++) applyStimulus(1, 8'(l * 17), 0, 0, 0);
            applyStimulus(0, 0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("pingPong", {24'd0, colourNum}, 32'(l * 17));
        end

        // Randomised traffic, including a mid-run reset
        for (int c = 0; c < 6000; c++) begin
            logic v, rs, sy;
            v  = ($urandom_range(0, 9) < 8);
            rs = ($urandom_range(0, 399) == 0);
            if (lineQ.size() == PIX) sy = ($urandom_range(0, 7) == 0);
            else                     sy = ($urandom_range(0, 249) == 0);
            if (c == 3000) applyReset();
            applyStimulus(v, 8'($urandom_range(0, 255)), rs, sy,
                          9'($urandom_range(0, 511)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
